// File: rtl/bus_arbiter.sv
// Two-master (CPU A, DMA B) round-robin arbiter onto a single shared bus.
// Ports: i_clock/i_reset, master A/B request bundles, o_bus_* to slave, i_bus_ready/i_bus_rdata back.
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_a_request,
  input  logic        i_a_rw,
  input  logic [31:0] i_a_address,
  input  logic [31:0] i_a_wdata,
  output logic [31:0] o_a_rdata,
  output logic        o_a_ready,
  output logic        o_a_error,
  input  logic        i_b_request,
  input  logic        i_b_rw,
  input  logic [31:0] i_b_address,
  input  logic [31:0] i_b_wdata,
  output logic [31:0] o_b_rdata,
  output logic        o_b_ready,
  output logic        o_b_error,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        grant_b;
  logic        prio_b;
  logic [7:0]  count;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        pick_b;
  logic        busy;
  logic        done;

  // B wins only if A is idle or B holds priority
  assign pick_b = i_b_request & (~i_a_request | prio_b);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      grant_b <= 1'b0;
      prio_b  <= 1'b0;
      count   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_a_request | i_b_request) begin
            grant_b <= pick_b;
            prio_b  <= ~pick_b;
            count   <= 8'd0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // slave completion takes precedence over timeout
          if (i_bus_ready) begin
            rdata_q <= i_bus_rdata;
            err_q   <= 1'b0;
            state   <= DONE;
          end else if (count == LAST) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state   <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  assign o_bus_request = busy;
  assign o_bus_rw      = busy & (grant_b ? i_b_rw : i_a_rw);
  assign o_bus_address = busy ? (grant_b ? i_b_address : i_a_address)
                              : 32'd0;
  assign o_bus_wdata   = busy ? (grant_b ? i_b_wdata : i_a_wdata)
                              : 32'd0;

  assign o_a_ready = done & ~grant_b;
  assign o_a_error = o_a_ready & err_q;
  assign o_a_rdata = o_a_ready ? rdata_q : 32'd0;

  assign o_b_ready = done & grant_b;
  assign o_b_error = o_b_ready & err_q;
  assign o_b_rdata = o_b_ready ? rdata_q : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Cycle-table bench for bus_arbiter (TIMEOUT=4).
// Each row: inputs for one cycle plus the outputs expected in that cycle.
module tb_bus_arbiter;

  localparam logic [31:0] A_ADDR  = 32'h0001_0004;
  localparam logic [31:0] A_WDATA = 32'h1111_2222;
  localparam logic [31:0] B_ADDR  = 32'h4000_0010;
  localparam logic [31:0] B_WDATA = 32'h00FF_00FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic        a_rw = 1'b0, b_rw = 1'b1;
  logic [31:0] a_addr = A_ADDR, b_addr = B_ADDR;
  logic [31:0] a_wd = A_WDATA, b_wd = B_WDATA;
  logic [31:0] a_rd, b_rd;
  logic        a_rdy, a_err, b_rdy, b_err;
  logic        bus_req, bus_rw;
  logic [31:0] bus_addr, bus_wd;
  logic        bus_rdy = 1'b0;
  logic [31:0] bus_rd = 32'd0;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_a_request  (a_req),
    .i_a_rw       (a_rw),
    .i_a_address  (a_addr),
    .i_a_wdata    (a_wd),
    .o_a_rdata    (a_rd),
    .o_a_ready    (a_rdy),
    .o_a_error    (a_err),
    .i_b_request  (b_req),
    .i_b_rw       (b_rw),
    .i_b_address  (b_addr),
    .i_b_wdata    (b_wd),
    .o_b_rdata    (b_rd),
    .o_b_ready    (b_rdy),
    .o_b_error    (b_err),
    .o_bus_request(bus_req),
    .o_bus_rw     (bus_rw),
    .o_bus_address(bus_addr),
    .o_bus_wdata  (bus_wd),
    .i_bus_ready  (bus_rdy),
    .i_bus_rdata  (bus_rd)
  );

  typedef struct {
    logic        rst;
    logic        a;
    logic        b;
    logic        rdy;
    logic [31:0] brd;
    logic        breq;
    logic [1:0]  own;
    logic        ardy;
    logic        aerr;
    logic        brdy;
    logic        berr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic a, logic b, logic rdy, logic [31:0] brd,
    logic breq, logic [1:0] own,
    logic ardy, logic aerr, logic brdy, logic berr,
    logic [31:0] rd);
    vec_t v;
    v.rst = r; v.a = a; v.b = b; v.rdy = rdy; v.brd = brd;
    v.breq = breq; v.own = own;
    v.ardy = ardy; v.aerr = aerr; v.brdy = brdy; v.berr = berr;
    v.rd = rd;
    return v;
  endfunction

  function automatic logic [199:0] pack_act();
    return {bus_req, bus_rw, bus_addr, bus_wd,
            a_rdy, a_err, a_rd, b_rdy, b_err, b_rd, 64'd0};
  endfunction

  function automatic logic [199:0] pack_exp(vec_t v);
    logic        rw;
    logic [31:0] ad, wd;
    rw = 1'b0; ad = 32'd0; wd = 32'd0;
    if (v.own == 2'd1) begin
      rw = 1'b0; ad = A_ADDR; wd = A_WDATA;
    end else if (v.own == 2'd2) begin
      rw = 1'b1; ad = B_ADDR; wd = B_WDATA;
    end
    return {v.breq, rw, ad, wd,
            v.ardy, v.aerr, (v.ardy ? v.rd : 32'd0),
            v.brdy, v.berr, (v.brdy ? v.rd : 32'd0), 64'd0};
  endfunction

  initial begin
    int n;
    logic [199:0] act, exp_v;

    vecs.push_back(mk(1,0,0,0,0,           0,0, 0,0,0,0,0));
    // A read alone, slave ready on third BUSY cycle
    vecs.push_back(mk(0,1,0,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,32'hDEADBEEF,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           0,0, 1,0,0,0,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0,0,0,           0,0, 0,0,0,0,0));
    // reset, then simultaneous requests alternate A, B, A
    vecs.push_back(mk(1,0,0,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,32'h12345678,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 1,0,0,0,32'h12345678));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,32'hCAFEF00D,1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 0,0,1,0,32'hCAFEF00D));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,32'h0000A5A5,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 1,0,0,0,32'h0000A5A5));
    // B timeout, request dropped mid-BUSY
    vecs.push_back(mk(0,0,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,           1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,           1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,           1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,           1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,           0,0, 0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,           0,0, 0,0,0,0,0));
    // ready coincides with last timeout cycle
    vecs.push_back(mk(0,1,0,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,1,32'h5A5AC3C3,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,           0,0, 1,0,0,0,32'h5A5AC3C3));
    vecs.push_back(mk(0,0,0,0,0,           0,0, 0,0,0,0,0));
    // reset mid-BUSY of B, priority returns to A
    vecs.push_back(mk(0,1,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           1,2, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,32'h0BADCAFE,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,           0,0, 1,0,0,0,32'h0BADCAFE));
    vecs.push_back(mk(0,0,0,0,0,           0,0, 0,0,0,0,0));

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst     = vecs[i].rst;
      a_req   = vecs[i].a;
      b_req   = vecs[i].b;
      bus_rdy = vecs[i].rdy;
      bus_rd  = vecs[i].brd;
      #1;
      act   = pack_act();
      exp_v = pack_exp(vecs[i]);
      nvec++;
      if (act !== exp_v) begin
        nbad++;
        $display("FAIL row%0d: got %h want %h", i, act[199:64],
                 exp_v[199:64]);
      end
    end

    // A alone, slave never answers: DONE with error after TIMEOUT cycles
    @(negedge clk);
    a_req = 1'b1; bus_rdy = 1'b0; bus_rd = 32'hFFFF_FFFF;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      n++;
      if (a_rdy) break;
    end
    nvec++;
    if (n != 5 || !a_rdy) begin
      nbad++;
      $display("FAIL a_timeout_lat: got %0d cycles rdy=%b want 5 rdy=1",
               n, a_rdy);
    end
    nvec++;
    if (a_err !== 1'b1 || a_rd !== 32'd0 || b_rdy !== 1'b0) begin
      nbad++;
      $display("FAIL a_timeout_val: got err=%b rd=%h brdy=%b want 1 0 0",
               a_err, a_rd, b_rdy);
    end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    nvec++;
    if (a_rdy !== 1'b0 || bus_req !== 1'b0) begin
      nbad++;
      $display("FAIL a_after_done: got rdy=%b breq=%b want 0 0",
               a_rdy, bus_req);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, is the maximum number of cycles a granted transfer waits for i_bus_ready (range 1..255).
REQ-002 i_clock  in  1  single clock; all state changes on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_a_request  in  1  master A (CPU) transfer request, held until o_a_ready/o_a_error.
REQ-005 i_a_rw  in  1  master A direction, 1=write, 0=read.
REQ-006 i_a_address  in  32  master A byte address.
REQ-007 i_a_wdata  in  32  master A write data.
REQ-008 o_a_rdata  out  32  master A read data, valid while o_a_ready=1.
REQ-009 o_a_ready  out  1  one-cycle completion pulse to master A.
REQ-010 o_a_error  out  1  one-cycle timeout pulse to master A, coincident with o_a_ready.
REQ-011 i_b_request, i_b_rw, i_b_address, i_b_wdata, o_b_rdata, o_b_ready, o_b_error: the same directions, widths and meanings for master B (DMA).
REQ-012 o_bus_request  out  1  request to the shared bus decode.
REQ-013 o_bus_rw, o_bus_address[31:0], o_bus_wdata[31:0]  out  forwarded from the granted master.
REQ-014 i_bus_ready  in  1  slave completion; i_bus_rdata  in  32  slave read data.

Function
REQ-015 States: IDLE, BUSY, DONE; state, grant, priority and a counter shall be registers.
REQ-016 IDLE: with no request, the block shall remain in IDLE with o_bus_request=0.
REQ-017 IDLE: with exactly one request, that master shall be granted and the next state shall be BUSY.
REQ-018 IDLE with both requests set: the master holding priority shall be granted; priority after reset is A.
REQ-019 On each grant, priority shall pass to the non-granted master (round-robin), so back-to-back requests alternate.
REQ-020 BUSY: o_bus_request=1, and o_bus_rw/address/wdata shall combinationally follow the granted master's inputs.
REQ-021 BUSY: when i_bus_ready=1, i_bus_rdata shall be latched, error=0, and the next state shall be DONE; minimum latency from grant to ready is 2 cycles.
REQ-022 BUSY: the counter shall reset to 0 on entry and increment each cycle; when it reaches TIMEOUT-1 without i_bus_ready, the latched rdata shall be 32'h00000000, error=1, and the next state shall be DONE.
REQ-023 If i_bus_ready and timeout coincide, ready shall win (error=0).
REQ-024 DONE: lasts exactly one cycle; o_bus_request=0; the granted master shall receive ready=1 and rdata=latched value, plus error if set; the next state shall be IDLE.
REQ-025 The non-granted master shall always see ready=0, error=0 and rdata=0.
REQ-026 A granted master shall deassert its request in the cycle after DONE; a request still high in IDLE shall be treated as a new transfer.
REQ-027 A request dropped during BUSY shall be ignored; the transfer shall complete normally (via ready or timeout).
REQ-028 When not in BUSY, o_bus_rw, o_bus_address and o_bus_wdata shall be 0.
REQ-029 The address shall be passed unmodified; region decode is outside this block.

Reset
REQ-030 Asserting i_reset shall immediately force state=IDLE, priority=A, counter=0, latched rdata=0 and error=0.
REQ-031 During reset, all outputs shall be 0, including mid-BUSY, where o_bus_request shall drop without waiting for a clock edge.
REQ-032 After reset release, the first arbitration shall occur at the first rising edge with i_reset=0.

Verification
REQ-033 A read 0x00010004 alone, slave ready 3 cycles after grant with rdata 0xDEADBEEF -> o_a_ready one cycle, o_a_rdata=0xDEADBEEF, o_bus_request low in DONE.
REQ-034 A and B request together after reset -> A granted first, B granted next, and a repeated simultaneous request then grants A again.
REQ-035 B write 0x40000010 with data 0x00FF00FF -> bus outputs mirror B during BUSY; A held high sees no ready.
REQ-036 TIMEOUT=4, i_bus_ready held 0 -> o_b_ready=1, o_b_error=1, rdata=0 exactly 4 cycles after grant, then IDLE.
REQ-037 i_bus_ready at the same cycle as counter reaches TIMEOUT-1 -> error=0 and the slave data returned.
REQ-038 Reset asserted mid-BUSY -> o_bus_request=0 without a clock edge; after release, priority=A.
